// File: rtl/particle_mem_ctrl.sv
// particle_mem_ctrl: arbitrates the particle-state BRAM port between the initialiser's fill stream
// and the stepper's read/write requests.
// The fill stream always wins. Within SIM, a write wins over a read.
// Optional macro PARTICLE_MEM_FILL_CHECK_EN adds a fill beat counter and the fill_error output.
`timescale 1ns / 1ps

module particle_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned RAM_WIDTH  = 64,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [15:0]           particle_count,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [RAM_WIDTH-1:0]  fill_data,
  input  logic                  fill_busy,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [RAM_WIDTH-1:0]  rd_data,
  output logic                  rd_data_valid,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]  wr_data,
  output logic                  wr_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]  mem_din,
  input  logic [RAM_WIDTH-1:0]  mem_dout,
`ifdef PARTICLE_MEM_FILL_CHECK_EN
  output logic                  fill_error,
`endif
  output logic                  fill_done,
  output logic                  sim_enable
);

  localparam int unsigned SetW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [SetW-1:0] SettleLast = SetW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StFill, StSettle, StSim} state_e;

  state_e                state_q, state_d;
  logic                  rst_ok_q, rst_ok_d;
  logic [SetW-1:0]       settle_cnt_q, settle_cnt_d;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic                  fill_done_q, fill_done_d;
  logic                  rd_hs;

  // Release flop: registered logic stays frozen until one full cycle after reset rises
  assign rst_ok_d = 1'b1;

  // Reset release synchroniser
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_ok_q <= 1'b0;
    else           rst_ok_q <= rst_ok_d;
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     state_q <= StIdle;
    else if (rst_ok_q) state_q <= state_d;
  end

  // FSM next-state logic; fill_busy restarts the fill from any state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fill_busy) state_d = StFill;
      StFill:   if (!fill_busy) state_d = StSettle;
      StSettle: begin
        if (fill_busy)                       state_d = StFill;
        else if (settle_cnt_q == SettleLast) state_d = StSim;
      end
      StSim:    if (fill_busy) state_d = StFill;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs and BRAM port mux
  always_comb begin
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_din       = '0;
    rd_ready      = 1'b0;
    wr_ready      = 1'b0;
    sim_enable    = 1'b0;
    rd_data_valid = rd_pipe_q[RD_LATENCY-1];
    rd_data       = rd_pipe_q[RD_LATENCY-1] ? mem_dout : '0;
    fill_done     = fill_done_q;
    if (rst_ok_q) begin
      sim_enable = (state_q == StSim);
      if (fill_busy) begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = fill_addr;
        mem_din  = fill_data;
      end else if (state_q == StSim) begin
        wr_ready = 1'b1;
        rd_ready = !wr_valid;
        if (wr_valid) begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = wr_addr;
          mem_din  = wr_data;
        end else if (rd_valid) begin
          mem_en   = 1'b1;
          mem_addr = rd_addr;
        end
      end
    end
  end

  assign rd_hs = rd_valid & rd_ready;

  // Next-state for settle counter, read-latency pipeline and fill_done pulse
  always_comb begin
    settle_cnt_d = '0;
    if (state_q == StSettle) settle_cnt_d = settle_cnt_q + 1'b1;
    rd_pipe_d    = '0;
    rd_pipe_d[0] = rd_hs;
    for (int unsigned i = 1; i < RD_LATENCY; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
    fill_done_d  = (state_q == StSettle) && (state_d == StSim);
  end

  // Datapath registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      settle_cnt_q <= '0;
      rd_pipe_q    <= '0;
      fill_done_q  <= 1'b0;
    end else if (rst_ok_q) begin
      settle_cnt_q <= settle_cnt_d;
      rd_pipe_q    <= rd_pipe_d;
      fill_done_q  <= fill_done_d;
    end
  end

`ifdef PARTICLE_MEM_FILL_CHECK_EN
  logic [16:0] fill_cnt_q, fill_cnt_d;
  logic        fill_error_q, fill_error_d;
  logic        fill_entry;

  // A fill beat seen outside FILL is the entry beat; it restarts the count at one
  assign fill_entry = fill_busy && (state_q != StFill);

  // Fill beat count and length check, evaluated as FILL hands over to SETTLE
  always_comb begin
    fill_cnt_d   = fill_cnt_q;
    fill_error_d = fill_error_q;
    if (fill_entry) begin
      fill_cnt_d   = 17'd1;
      fill_error_d = 1'b0;
    end else if (fill_busy) begin
      fill_cnt_d = fill_cnt_q + 17'd1;
    end else if (state_q == StFill) begin
      fill_error_d = (fill_cnt_q != {particle_count, 1'b0});
    end
  end

  // Fill check registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fill_cnt_q   <= '0;
      fill_error_q <= 1'b0;
    end else if (rst_ok_q) begin
      fill_cnt_q   <= fill_cnt_d;
      fill_error_q <= fill_error_d;
    end
  end

  assign fill_error = fill_error_q;
`else
  logic unused_particle_count;
  assign unused_particle_count = ^particle_count;
`endif

endmodule
